// File: rtl/tb_button_stim_gen.sv
// Push-button stimulus generator: waits for the DUT's LEDs to leave all-ones, settles,
// then drives timed toggle / pulse / bounced-toggle events on the latched channel mask.
module tb_button_stim_gen #(
    parameter int NUM_CH        = 4,
    parameter int LED_W         = 4,
    parameter int POLL_CYCLES   = 50,
    parameter int INIT_CYCLES   = 800000,
    parameter int PERIOD_CYCLES = 300000,
    parameter int NUM_EVENTS    = 20,
    parameter int PULSE_CYCLES  = 1000,
    parameter int BOUNCE_EDGES  = 3,
    parameter int BOUNCE_CYCLES = 20
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [LED_W-1:0]  led_i,
    output logic [NUM_CH-1:0] buttons_o,
    output logic              busy,
    output logic              done,
    output logic [15:0]       event_cnt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max2(max2(max2(POLL_CYCLES, INIT_CYCLES), max2(PERIOD_CYCLES, PULSE_CYCLES)),
                               BOUNCE_CYCLES);
    localparam int CW   = $clog2(MAXP + 1);
    localparam int NTOG = 2 * BOUNCE_EDGES + 1;
    localparam int EW   = $clog2(NTOG + 1);

    typedef enum logic [2:0] {IDLE, WAIT_LED, INIT, GAP, ACT, BOUNCE, DONE_S} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [NUM_CH-1:0] btn_q, btn_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       evc_q, evc_d;
    logic              ev_done;

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            btn_q   <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            evc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            btn_q   <= btn_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            evc_q   <= evc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        edge_d  = edge_q;
        btn_d   = btn_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        evc_d   = evc_q;
        ev_done = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    mode_d  = mode;
                    mask_d  = ch_mask;
                    evc_d   = '0;
                    state_d = WAIT_LED;
                end
            end
            WAIT_LED: begin
                if (cnt_q == CW'(POLL_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (led_i != '1) state_d = INIT;
                end
            end
            INIT: begin
                if (cnt_q == CW'(INIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (NUM_EVENTS == 0) ? DONE_S : GAP;
                end
            end
            // The gap runs one cycle past PERIOD_CYCLES: the event lands on the following cycle.
            GAP: begin
                if (cnt_q == CW'(PERIOD_CYCLES)) begin
                    cnt_d = '0;
                    case (mode_q)
                        2'd1: begin
                            btn_d   = btn_q | mask_q;
                            state_d = ACT;
                        end
                        2'd2: begin
                            btn_d  = btn_q ^ mask_q;
                            edge_d = EW'(1);
                            if (NTOG == 1) ev_done = 1'b1;
                            else           state_d = BOUNCE;
                        end
                        default: begin
                            btn_d   = btn_q ^ mask_q;
                            ev_done = 1'b1;
                        end
                    endcase
                end
            end
            ACT: begin
                if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                    btn_d   = btn_q & ~mask_q;
                    ev_done = 1'b1;
                end
            end
            BOUNCE: begin
                if (cnt_q == CW'(BOUNCE_CYCLES - 1)) begin
                    cnt_d  = '0;
                    btn_d  = btn_q ^ mask_q;
                    edge_d = edge_q + EW'(1);
                    if (edge_q == EW'(NTOG - 1)) ev_done = 1'b1;
                end
            end
            DONE_S: begin
                cnt_d = '0;
                if (!enable) begin
                    btn_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ev_done) begin
            cnt_d = '0;
            if (evc_q != 16'hFFFF) evc_d = evc_q + 16'd1;
            state_d = (evc_d == 16'(NUM_EVENTS)) ? DONE_S : GAP;
        end

        // Abort wins over any in-flight event; the event count is kept for inspection.
        if (!enable && state_q != IDLE && state_q != DONE_S) begin
            state_d = IDLE;
            btn_d   = '0;
            cnt_d   = '0;
            edge_d  = '0;
            evc_d   = evc_q;
        end
    end

    assign buttons_o = btn_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE_S);
    assign done      = (state_q == DONE_S);
    assign event_cnt = evc_q;

endmodule
